coffee_order_ctrl: RTL and testbench

//  Front-end order controller that drives the brew FSM's start/coffee_sel/done handshake.
//  - Accumulates coin credit and validates each drink selection against its price.
//  - Issues a one-cycle brew_start with brew_sel held stable, then waits for brew_done.
//  - Returns change, or refunds on cancel; faults if the brewer never reports done.

---
 rtl/coffee_order_ctrl.sv | 133 +++++++++++++
 tb/tb_coffee_order_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coffee_order_ctrl.sv
// Order front-end for the coffee machine: collects coin credit, validates drink
// selections against their prices, hands off to the brewer and returns change.
module coffee_order_ctrl #(
    parameter int PRICE_0     = 10,
    parameter int PRICE_1     = 12,
    parameter int PRICE_2     = 15,
    parameter int PRICE_3     = 15,
    parameter int CREDIT_MAX  = 255,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_in,
    input  logic [7:0] coin_val,
    input  logic       sel_req,
    input  logic [1:0] sel_code,
    input  logic       cancel,
    output logic       brew_start,
    output logic [1:0] brew_sel,
    input  logic       brew_done,
    output logic [7:0] credit,
    output logic       coin_reject,
    output logic       err_funds,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       busy,
    output logic       fault,
    output logic [2:0] ctrl_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] BREW   = 3'd2;
    localparam logic [2:0] CHANGE = 3'd3;
    localparam logic [2:0] FAULT  = 3'd4;

    localparam int              CNT_W        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [8:0]       CREDIT_LIMIT = 9'(CREDIT_MAX);

    logic [2:0]       state;
    logic [CNT_W-1:0] timeout_cnt;
    logic [8:0]       coin_sum;
    logic             coin_ok;
    logic [7:0]       credit_coin;
    logic [7:0]       price;

    // Credit as it would stand after this cycle's coin; the 9-bit sum catches overflow.
    always_comb begin
        coin_sum    = {1'b0, credit} + {1'b0, coin_val};
        coin_ok     = coin_in && (coin_sum <= CREDIT_LIMIT);
        credit_coin = coin_ok ? coin_sum[7:0] : credit;
        case (sel_code)
            2'b00:   price = 8'(PRICE_0);
            2'b01:   price = 8'(PRICE_1);
            2'b10:   price = 8'(PRICE_2);
            default: price = 8'(PRICE_3);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= 8'd0;
            brew_sel    <= 2'b00;
            change_amt  <= 8'd0;
            timeout_cnt <= '0;
            coin_reject <= 1'b0;
            err_funds   <= 1'b0;
        end else begin
            // Outside IDLE every coin is bounced back.
            coin_reject <= (state == IDLE) ? (coin_in && !coin_ok) : coin_in;
            err_funds   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cancel) begin
                        if (credit_coin != 8'd0) begin
                            change_amt <= credit_coin;
                            credit     <= 8'd0;
                            state      <= CHANGE;
                        end
                    end else if (sel_req) begin
                        // Affordability uses credit before this cycle's coin.
                        if (credit >= price) begin
                            brew_sel <= sel_code;
                            credit   <= credit_coin - price;
                            state    <= START;
                        end else begin
                            err_funds <= 1'b1;
                            credit    <= credit_coin;
                        end
                    end else begin
                        credit <= credit_coin;
                    end
                end
                START: begin
                    timeout_cnt <= '0;
                    state       <= BREW;
                end
                BREW: begin
                    if (brew_done) begin
                        if (credit != 8'd0) begin
                            change_amt <= credit;
                            credit     <= 8'd0;
                            state      <= CHANGE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timeout_cnt == CNT_LAST) begin
                        state <= FAULT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                CHANGE: begin
                    credit <= 8'd0;
                    state  <= IDLE;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign brew_start   = (state == START);
    assign change_valid = (state == CHANGE);
    assign busy         = (state != IDLE);
    assign fault        = (state == FAULT);
    assign ctrl_state   = state;

endmodule

// File: tb/tb_coffee_order_ctrl.sv
// Bench for coffee_order_ctrl: pulse outputs are matched against a queue of
// expected events tagged with the cycle on which they must appear.
module tb_coffee_order_ctrl;

    localparam int K_BREW   = 0;
    localparam int K_CHANGE = 1;
    localparam int K_ERR    = 2;
    localparam int K_REJ    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_in = 1'b0;
    logic [7:0] coin_val = 8'd0;
    logic       sel_req = 1'b0;
    logic [1:0] sel_code = 2'b00;
    logic       cancel = 1'b0;
    logic       brew_done = 1'b0;
    logic       brew_start;
    logic [1:0] brew_sel;
    logic [7:0] credit;
    logic       coin_reject;
    logic       err_funds;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       busy;
    logic       fault;
    logic [2:0] ctrl_state;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   check_count = 0;
    int   error_count = 0;

    coffee_order_ctrl dut (
        .clk(clk), .reset(reset), .coin_in(coin_in), .coin_val(coin_val),
        .sel_req(sel_req), .sel_code(sel_code), .cancel(cancel),
        .brew_start(brew_start), .brew_sel(brew_sel), .brew_done(brew_done),
        .credit(credit), .coin_reject(coin_reject), .err_funds(err_funds),
        .change_valid(change_valid), .change_amt(change_amt), .busy(busy),
        .fault(fault), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // The event is due on the edge that samples the next applied stimulus.
    task automatic expectEvent(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + 1;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic matchEvent(input int kind, input string name, input int val);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].kind == kind) idx = i;
        end
        if (idx < 0) begin
            checkOutput({name, "_unexpected"}, 1, 0);
        end else begin
            checkOutput({name, "_cycle"}, cyc, exp_q[idx].cyc);
            checkOutput({name, "_value"}, val, exp_q[idx].val);
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (brew_start)   matchEvent(K_BREW, "brew_start", int'(brew_sel));
            if (change_valid) matchEvent(K_CHANGE, "change", int'(change_amt));
            if (err_funds)    matchEvent(K_ERR, "err_funds", 0);
            if (coin_reject)  matchEvent(K_REJ, "coin_reject", 0);
        end
    end

    // Called at a falling edge; inputs are held for exactly one rising edge.
    task automatic applyStimulus(input logic c_in, input logic [7:0] c_val, input logic s_req,
                                 input logic [1:0] s_code, input logic canc, input logic done);
        coin_in   = c_in;
        coin_val  = c_val;
        sel_req   = s_req;
        sel_code  = s_code;
        cancel    = canc;
        brew_done = done;
        @(negedge clk);
        coin_in   = 1'b0;
        coin_val  = 8'd0;
        sel_req   = 1'b0;
        sel_code  = 2'b00;
        cancel    = 1'b0;
        brew_done = 1'b0;
    endtask

    task automatic coinIn(input logic [7:0] v);
        applyStimulus(1'b1, v, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic selectDrink(input logic [1:0] code);
        applyStimulus(1'b0, 8'd0, 1'b1, code, 1'b0, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_state"}, ctrl_state, 0);
        checkOutput({tag, "_credit"}, credit, 0);
        checkOutput({tag, "_brew_sel"}, brew_sel, 0);
        checkOutput({tag, "_change_amt"}, change_amt, 0);
        checkOutput({tag, "_pulses"}, {brew_start, coin_reject, err_funds, change_valid}, 0);
        checkOutput({tag, "_busy_fault"}, {busy, fault}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        // Exact payment: no change afterwards
        coinIn(8'd5);
        checkOutput("t1_credit5", credit, 5);
        coinIn(8'd5);
        checkOutput("t1_credit10", credit, 10);
        expectEvent(K_BREW, 0);
        selectDrink(2'b00);
        checkOutput("t1_credit0", credit, 0);
        checkOutput("t1_start", ctrl_state, 1);
        idleCycles(1);
        checkOutput("t1_brew", ctrl_state, 2);
        idleCycles(3);
        checkOutput("t1_brew_held", ctrl_state, 2);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("t1_idle", ctrl_state, 0);
        checkOutput("t1_busy", busy, 0);

        // Overpayment returns change
        coinIn(8'd10);
        coinIn(8'd10);
        checkOutput("t2_credit20", credit, 20);
        expectEvent(K_BREW, 2);
        selectDrink(2'b10);
        checkOutput("t2_credit5", credit, 5);
        idleCycles(1);
        checkOutput("t2_brew_sel", brew_sel, 2);
        expectEvent(K_CHANGE, 5);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("t2_change_state", ctrl_state, 3);
        checkOutput("t2_credit0", credit, 0);
        idleCycles(1);
        checkOutput("t2_idle", ctrl_state, 0);

        // Insufficient funds, then refund
        coinIn(8'd10);
        expectEvent(K_ERR, 0);
        selectDrink(2'b10);
        checkOutput("t3_credit_kept", credit, 10);
        checkOutput("t3_idle", ctrl_state, 0);
        expectEvent(K_CHANGE, 10);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b1, 1'b0);
        checkOutput("t3_refund_state", ctrl_state, 3);
        idleCycles(1);

        // Credit ceiling and coin rejection outside IDLE
        coinIn(8'd200);
        coinIn(8'd50);
        checkOutput("t4_credit250", credit, 250);
        expectEvent(K_REJ, 0);
        coinIn(8'd10);
        checkOutput("t4_reject_kept", credit, 250);
        coinIn(8'd5);
        checkOutput("t4_credit_max", credit, 255);
        expectEvent(K_REJ, 0);
        coinIn(8'd1);
        checkOutput("t4_over_max", credit, 255);
        expectEvent(K_BREW, 0);
        selectDrink(2'b00);
        checkOutput("t4_credit245", credit, 245);
        idleCycles(1);
        expectEvent(K_REJ, 0);
        coinIn(8'd7);
        checkOutput("t4_brew_coin", credit, 245);
        expectEvent(K_CHANGE, 245);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b1);
        expectEvent(K_REJ, 0);
        coinIn(8'd3);
        checkOutput("t4_change_coin", credit, 0);
        checkOutput("t4_idle", ctrl_state, 0);

        // Same-cycle priorities
        coinIn(8'd10);
        coinIn(8'd5);
        expectEvent(K_CHANGE, 15);
        applyStimulus(1'b0, 8'd0, 1'b1, 2'b00, 1'b1, 1'b0);
        checkOutput("t5_cancel_wins", ctrl_state, 3);
        idleCycles(1);
        coinIn(8'd10);
        expectEvent(K_BREW, 0);
        applyStimulus(1'b1, 8'd5, 1'b1, 2'b00, 1'b0, 1'b0);
        checkOutput("t5_coin_sel_credit", credit, 5);
        idleCycles(1);
        expectEvent(K_CHANGE, 5);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b1);
        idleCycles(1);
        coinIn(8'd8);
        expectEvent(K_ERR, 0);
        applyStimulus(1'b1, 8'd5, 1'b1, 2'b00, 1'b0, 1'b0);
        checkOutput("t5_precoin_credit", credit, 13);
        checkOutput("t5_precoin_state", ctrl_state, 0);
        expectEvent(K_CHANGE, 13);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b1, 1'b0);
        idleCycles(1);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b1, 1'b0);
        checkOutput("t5_cancel_empty", ctrl_state, 0);

        // Done on the timeout cycle wins
        coinIn(8'd10);
        expectEvent(K_BREW, 0);
        selectDrink(2'b00);
        idleCycles(1);
        idleCycles(999);
        checkOutput("t6_still_brew", ctrl_state, 2);
        applyStimulus(1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("t6_done_wins", ctrl_state, 0);

        // Timeout into FAULT
        coinIn(8'd15);
        expectEvent(K_BREW, 0);
        selectDrink(2'b00);
        idleCycles(1);
        idleCycles(999);
        checkOutput("t6_pre_fault", ctrl_state, 2);
        checkOutput("t6_pre_fault_flag", fault, 0);
        idleCycles(1);
        checkOutput("t6_fault_state", ctrl_state, 4);
        checkOutput("t6_fault_flag", {fault, busy}, 2'b11);
        expectEvent(K_REJ, 0);
        coinIn(8'd5);
        checkOutput("t6_fault_credit", credit, 5);
        applyStimulus(1'b0, 8'd0, 1'b1, 2'b00, 1'b1, 1'b0);
        checkOutput("t6_fault_sticky", ctrl_state, 4);
        reset = 1'b1;
        #1;
        checkOutput("t6_fault_reset", {fault, ctrl_state}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset in the middle of a brew
        coinIn(8'd20);
        expectEvent(K_BREW, 1);
        selectDrink(2'b01);
        checkOutput("t6_credit8", credit, 8);
        idleCycles(1);
        checkOutput("t6_brew_sel1", brew_sel, 1);
        reset = 1'b1;
        #1;
        checkAllZero("t6_async_reset");
        @(negedge clk);
        reset = 1'b0;
        idleCycles(2);

        checkOutput("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
